mac_result_writer: RTL and testbench
====================================

Name: mac_result_writer

Overview:
- Result-side sink for the pipelined 3x3 multiplier datapath.
- The operand side issues one BRAM address per cycle. This block tracks each issue through the fixed pipeline latency and captures the matching 6-bit product when it emerges.
- Each captured product is accumulated into a running sum, and each new sum is written sequentially into a result BRAM port.
- It closes the loop of operand read, multiply and result write for one run of NUM_SAMPLES.

Parameters:
- PROD_W, 6: product width from the multiplier.
- ACC_W, 10: accumulator and write-data width.
- ADDR_W, 4: result memory address width.
- PIPE_LAT, 8: cycles from an operand-address issue to its product being valid on prod.
- NUM_SAMPLES, 16: writes per run; must be between 1 and 2^ADDR_W.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that begins a run.
- issue, in, 1: an operand address was presented to the operand memory this cycle.
- prod, in, PROD_W: multiplier output, valid PIPE_LAT cycles after the matching issue.
- wr_en, out, 1: result memory write strobe.
- wr_addr, out, ADDR_W: result memory write address.
- wr_data, out, ACC_W: accumulated value being written.
- acc, out, ACC_W: current accumulator value.
- busy, out, 1: high in RUN.
- done, out, 1: high in DONE.
- overflow, out, 1: sticky; accumulator carried out of ACC_W during this run.

Behaviour:

Reset:
- reset=1, asynchronous: all outputs are 0 and the state is IDLE.
- Delay line, write counter and accumulator are all cleared.
- Reset mid-run aborts the run immediately; no further wr_en is produced.

State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 goes to RUN next cycle.
  - On the same edge, clear acc, overflow, wr_addr, the write count and every delay-line tap.
- RUN:
  - The delay line is PIPE_LAT bits deep and shifts every cycle, inserting issue.
  - Issues during the start cycle are dropped; issues in IDLE and DONE are not recorded.
  - The tap out equals issue from exactly PIPE_LAT cycles earlier.
  - When tap out=1, on the next edge: acc <= acc + zero-extended prod, wrapping modulo 2^ACC_W.
  - On that same edge: wr_en<=1, wr_data<=the new acc, wr_addr<=the current write count, and the write count increments.
  - wr_en is a registered 1-cycle pulse; wr_addr and wr_data are valid in the same cycle as wr_en.
  - overflow is set on any addition that produces a carry out of ACC_W; it stays set until the next start or reset.
  - When the write count reaches NUM_SAMPLES on a write edge, the next state is DONE.
  - Taps arriving after the NUM_SAMPLES-th write are discarded; acc is unchanged and wr_en stays 0.
- DONE:
  - done=1, and acc and overflow hold their values.
  - start=1 goes to RUN, with the same clearing as from IDLE (back-to-back runs are allowed).
  - With no start, DONE persists; there is no automatic return to IDLE except through reset.
- start while in RUN: ignored.
- wr_addr wraps at 2^ADDR_W, which can only be reached when NUM_SAMPLES=2^ADDR_W.
- Throughput: one write per cycle when issue is held high continuously.
- Latency from an issue to its wr_en: PIPE_LAT+1 cycles.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - default widths PROD_W=6, ACC_W=10, ADDR_W=4;
  - PIPE_LAT default 8, so the operand-fetch and result sides share one latency constant.
- One sub-module: valid_delay_line.
  - Parameter DEPTH.
  - Ports: clk, reset, clr, din, dout.
  - A shift register with asynchronous reset and synchronous clear.

Test Plan:
- Single issue: start, wait 1 cycle, issue=1 for 1 cycle, prod=5 at the tap cycle.
  - Expect wr_en exactly 9 cycles after the issue, with wr_addr=0, wr_data=5 and acc=5.
- Full run: issue held high 16 cycles, prod=49 (7x7) each time.
  - Expect 16 consecutive wr_en with wr_addr 0..15 and wr_data 49, 98, ..., 784.
  - Then done=1, busy=0, overflow=0.
- Overflow: ACC_W=8, NUM_SAMPLES=5, five products of 63.
  - 4th write is wr_data=252, overflow=0.
  - 5th write is wr_data=59 (315-256), overflow=1, then done=1.
- Surplus and ignored inputs: NUM_SAMPLES=4 with 6 issues.
  - Expect exactly 4 writes, and acc equal to the sum of the first 4 products.
  - Issue pulses in IDLE before start produce no writes.
- Reset mid-run: assert reset after the 3rd write of a 16-sample run, with issues still in flight.
  - All outputs go to 0 asynchronously.
  - No wr_en after reset is released.
  - A new start then behaves exactly as the single-issue case.
- Back-to-back runs: start in DONE.
  - acc, overflow and wr_addr clear, and the second run's first write has wr_addr=0.

Source files
------------

// File: rtl/mac_result_writer_pkg.sv
// Shared types and default widths for the operand-fetch / multiply / result-write loop.
// The multiplier latency lives here so both sides of the pipeline agree on it.
package mac_result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DFLT_PROD_W      = 6;
  localparam int DFLT_ACC_W       = 10;
  localparam int DFLT_ADDR_W      = 4;
  localparam int MUL_PIPE_LAT     = 8;
  localparam int DFLT_NUM_SAMPLES = 16;

endpackage

// File: rtl/mac_result_writer_delay.sv
// Single-bit valid shift register: dout is din delayed by DEPTH cycles.
// Asynchronous reset, synchronous clear of every tap; no backpressure.
module valid_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] taps_q;
  logic [DEPTH-1:0] taps_d;

  always_comb begin
    taps_d = '0;
    if (!clr) begin
      taps_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign dout = taps_q[DEPTH-1];

endmodule

// File: rtl/mac_result_writer.sv
// Captures multiplier products PIPE_LAT cycles after each issue, accumulates them and writes each sum.
// Issue-to-wr_en latency PIPE_LAT+1; no backpressure, one write per cycle sustained.
module mac_result_writer
  import mac_result_writer_pkg::*;
#(
  parameter int PROD_W      = DFLT_PROD_W,
  parameter int ACC_W       = DFLT_ACC_W,
  parameter int ADDR_W      = DFLT_ADDR_W,
  parameter int PIPE_LAT    = MUL_PIPE_LAT,
  parameter int NUM_SAMPLES = DFLT_NUM_SAMPLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              issue,
  input  logic [PROD_W-1:0] prod,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  // One extra bit so the count can reach NUM_SAMPLES = 2^ADDR_W.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ACC_W:0]    sum;
  logic              launch;
  logic              record;
  logic              tap;

  // A start outside RUN clears the taps, so issues on the start cycle never land.
  assign launch = start && (state_q != RUN);
  assign record = issue && (state_q == RUN);

  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .din   (record),
    .dout  (tap)
  );

  always_comb begin
    sum       = {1'b0, acc_q} + (ACC_W+1)'(prod);
    state_d   = state_q;
    acc_d     = acc_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          acc_d     = '0;
          wr_data_d = '0;
          wr_addr_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      RUN: begin
        if (tap) begin
          acc_d     = sum[ACC_W-1:0];
          wr_data_d = sum[ACC_W-1:0];
          ovf_d     = ovf_q | sum[ACC_W];
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d     = cnt_q + 1'b1;
          if (cnt_d == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign acc      = acc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// Bench for mac_result_writer: three parameterisations share one stimulus stream;
// expected writes come from running integer sums over the list of accepted products.
module tb_mac_result_writer;

  localparam int PL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       issue = 1'b0;
  logic [5:0] prod = 6'd0;

  logic       d_wr_en, d_busy, d_done, d_overflow;
  logic [3:0] d_wr_addr;
  logic [9:0] d_wr_data, d_acc;
  logic       o_wr_en, o_busy, o_done, o_overflow;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data, o_acc;
  logic       s_wr_en, s_busy, s_done, s_overflow;
  logic [3:0] s_wr_addr;
  logic [9:0] s_wr_data, s_acc;

  mac_result_writer u_def (
    .clk(clk), .reset(reset), .start(start), .issue(issue), .prod(prod),
    .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data), .acc(d_acc),
    .busy(d_busy), .done(d_done), .overflow(d_overflow)
  );

  mac_result_writer #(.ACC_W(8), .NUM_SAMPLES(5)) u_ovf (
    .clk(clk), .reset(reset), .start(start), .issue(issue), .prod(prod),
    .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data), .acc(o_acc),
    .busy(o_busy), .done(o_done), .overflow(o_overflow)
  );

  mac_result_writer #(.NUM_SAMPLES(4)) u_sur (
    .clk(clk), .reset(reset), .start(start), .issue(issue), .prod(prod),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .acc(s_acc),
    .busy(s_busy), .done(s_done), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [9:0] data;
    logic       ovf;
  } obs_t;

  obs_t       obs_d[$];
  obs_t       obs_o[$];
  obs_t       obs_s[$];
  logic [5:0] issued[$];
  logic [5:0] prod_at[0:63];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (d_wr_en) obs_d.push_back('{cyc: cyc, addr: d_wr_addr, data: d_wr_data, ovf: d_overflow});
      if (o_wr_en) obs_o.push_back('{cyc: cyc, addr: o_wr_addr, data: {2'b00, o_wr_data}, ovf: o_overflow});
      if (s_wr_en) obs_s.push_back('{cyc: cyc, addr: s_wr_addr, data: s_wr_data, ovf: s_overflow});
    end
  end

  // Reference: write k carries the sum of the first k accepted products, modulo 2^w.
  function automatic int run_sum(input int k);
    int s = 0;
    for (int i = 0; i < k && i < issued.size(); i++) s += int'(issued[i]);
    return s;
  endfunction

  function automatic int exp_sum(input int k, input int w);
    return run_sum(k) % (1 << w);
  endfunction

  function automatic logic exp_ovf(input int k, input int w);
    return run_sum(k) >= (1 << w);
  endfunction

  // One clock of stimulus; p is the product the multiplier will present PL cycles later.
  task automatic step(input logic st, input logic iss, input logic [5:0] p);
    start = st;
    issue = iss;
    prod_at[(cyc + PL) % 64] = p;
    prod = prod_at[cyc % 64];
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    obs_d.delete();
    obs_o.delete();
    obs_s.delete();
    issued.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    vectors++;
    if ({d_wr_en, d_wr_addr, d_wr_data, d_acc, d_busy, d_done, d_overflow} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_def: got %h want 0", {d_wr_en, d_wr_addr, d_wr_data, d_acc, d_busy, d_done, d_overflow});
    end
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_acc, o_busy, o_done, o_overflow} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %h want 0", {o_wr_en, o_wr_addr, o_wr_data, o_acc, o_busy, o_done, o_overflow});
    end
    vectors++;
    if ({s_wr_en, s_wr_addr, s_wr_data, s_acc, s_busy, s_done, s_overflow} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_sur: got %h want 0", {s_wr_en, s_wr_addr, s_wr_data, s_acc, s_busy, s_done, s_overflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_issue(input bit with_reset);
    int ci;
    if (with_reset) do_reset();
    obs_d.delete();
    issued.delete();
    step(1'b1, 1'b0, 6'($urandom));
    ci = cyc;
    step(1'b0, 1'b1, 6'd5);
    issued.push_back(6'd5);
    idle(14);
    vectors++;
    if (obs_d.size() != 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes want 1", obs_d.size());
    end else begin
      vectors++;
      if (obs_d[0].cyc - ci != PL + 1) begin
        miscompares++;
        $display("FAIL single_latency: got %0d want %0d", obs_d[0].cyc - ci, PL + 1);
      end
      vectors++;
      if (obs_d[0].addr !== 4'd0 || obs_d[0].data !== 10'd5) begin
        miscompares++;
        $display("FAIL single_write: got addr %0d data %0d want 0/5", obs_d[0].addr, obs_d[0].data);
      end
    end
    vectors++;
    if (d_acc !== 10'd5 || d_busy !== 1'b1 || d_done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_state: got acc %0d busy %b done %b want 5/1/0", d_acc, d_busy, d_done);
    end
  endtask

  task automatic test_full_run();
    do_reset();
    step(1'b1, 1'b0, 6'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 6'd49);
      issued.push_back(6'd49);
    end
    idle(12);
    vectors++;
    if (obs_d.size() != 16) begin
      miscompares++;
      $display("FAIL full_count: got %0d writes want 16", obs_d.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (obs_d[i].addr !== 4'(i) || obs_d[i].data !== 10'(49 * (i + 1)) ||
            obs_d[i].cyc != obs_d[0].cyc + i) begin
          miscompares++;
          $display("FAIL full_write%0d: got addr %0d data %0d cyc %0d want %0d/%0d/%0d", i,
                   obs_d[i].addr, obs_d[i].data, obs_d[i].cyc, i, 49 * (i + 1), obs_d[0].cyc + i);
        end
      end
    end
    vectors++;
    if (d_done !== 1'b1 || d_busy !== 1'b0 || d_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_end: got done %b busy %b ovf %b want 1/0/0", d_done, d_busy, d_overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 1'b0, 6'($urandom));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 6'd63);
      issued.push_back(6'd63);
    end
    idle(12);
    vectors++;
    if (obs_o.size() != 5) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d writes want 5", obs_o.size());
    end else begin
      vectors++;
      if (obs_o[3].data !== 10'd252 || obs_o[3].ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL ovf_4th: got data %0d ovf %b want 252/0", obs_o[3].data, obs_o[3].ovf);
      end
      vectors++;
      if (obs_o[4].data !== 10'd59 || obs_o[4].ovf !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_5th: got data %0d ovf %b want 59/1", obs_o[4].data, obs_o[4].ovf);
      end
    end
    vectors++;
    if (o_done !== 1'b1 || o_overflow !== 1'b1 || o_acc !== 8'd59) begin
      miscompares++;
      $display("FAIL ovf_end: got done %b ovf %b acc %0d want 1/1/59", o_done, o_overflow, o_acc);
    end
  endtask

  task automatic test_surplus();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'($urandom));
    step(1'b1, 1'b1, 6'($urandom));
    for (int i = 0; i < 6; i++) begin
      logic [5:0] p;
      p = 6'($urandom);
      step(1'b0, 1'b1, p);
      issued.push_back(p);
    end
    idle(14);
    vectors++;
    if (obs_d.size() != 6) begin
      miscompares++;
      $display("FAIL surplus_def_count: got %0d writes want 6", obs_d.size());
    end
    vectors++;
    if (obs_s.size() != 4) begin
      miscompares++;
      $display("FAIL surplus_count: got %0d writes want 4", obs_s.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs_s[i].data !== 10'(exp_sum(i + 1, 10)) || obs_s[i].addr !== 4'(i)) begin
          miscompares++;
          $display("FAIL surplus_write%0d: got addr %0d data %0d want %0d/%0d", i,
                   obs_s[i].addr, obs_s[i].data, i, exp_sum(i + 1, 10));
        end
      end
    end
    vectors++;
    if (s_acc !== 10'(exp_sum(4, 10)) || s_done !== 1'b1) begin
      miscompares++;
      $display("FAIL surplus_acc: got acc %0d done %b want %0d/1", s_acc, s_done, exp_sum(4, 10));
    end
  endtask

  task automatic test_random_runs();
    for (int run = 0; run < 4; run++) begin
      do_reset();
      step(1'b1, 1'b0, 6'($urandom));
      for (int i = 0; i < 30; i++) begin
        logic       iss;
        logic [5:0] p;
        iss = 1'($urandom);
        p = 6'($urandom);
        step(1'b0, iss, p);
        if (iss) issued.push_back(p);
      end
      idle(12);
      for (int k = 0; k < 3; k++) begin
        obs_t q[$];
        int   n_lim;
        int   n_exp;
        int   w;
        logic dn;
        case (k)
          0:       begin q = obs_d; n_lim = 16; w = 10; dn = d_done; end
          1:       begin q = obs_o; n_lim = 5;  w = 8;  dn = o_done; end
          default: begin q = obs_s; n_lim = 4;  w = 10; dn = s_done; end
        endcase
        n_exp = (issued.size() < n_lim) ? issued.size() : n_lim;
        vectors++;
        if (q.size() != n_exp) begin
          miscompares++;
          $display("FAIL rand_count run%0d inst%0d: got %0d want %0d", run, k, q.size(), n_exp);
        end else begin
          for (int i = 0; i < n_exp; i++) begin
            vectors++;
            if (q[i].addr !== 4'(i) || q[i].data !== 10'(exp_sum(i + 1, w)) ||
                q[i].ovf !== exp_ovf(i + 1, w)) begin
              miscompares++;
              $display("FAIL rand_write run%0d inst%0d #%0d: got %0d/%0d/%b want %0d/%0d/%b", run, k, i,
                       q[i].addr, q[i].data, q[i].ovf, i, exp_sum(i + 1, w), exp_ovf(i + 1, w));
            end
          end
        end
        vectors++;
        if (dn !== (issued.size() >= n_lim)) begin
          miscompares++;
          $display("FAIL rand_done run%0d inst%0d: got %b want %b", run, k, dn, issued.size() >= n_lim);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int  wrs;
    bit  hit;
    wrs = 0;
    hit = 0;
    do_reset();
    step(1'b1, 1'b0, 6'($urandom));
    for (int k = 0; k < 40 && !hit; k++) begin
      step(1'b0, k < 16, 6'($urandom));
      if (d_wr_en === 1'b1) wrs++;
      if (wrs == 3) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL midrun_wait: got %0d writes want 3 within 40 cycles", wrs);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({d_wr_en, d_wr_addr, d_wr_data, d_acc, d_busy, d_done, d_overflow} !== 28'd0) begin
      miscompares++;
      $display("FAIL midrun_async: got %h want 0", {d_wr_en, d_wr_addr, d_wr_data, d_acc, d_busy, d_done, d_overflow});
    end
    idle(2);
    reset = 1'b0;
    obs_d.delete();
    obs_o.delete();
    obs_s.delete();
    idle(20);
    vectors++;
    if (obs_d.size() + obs_o.size() + obs_s.size() != 0 || d_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_quiet: got %0d writes busy %b want 0/0",
               obs_d.size() + obs_o.size() + obs_s.size(), d_busy);
    end
    test_single_issue(1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 6'($urandom));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 6'd63);
    idle(12);
    vectors++;
    if (d_done !== 1'b1 || o_overflow !== 1'b1 || d_wr_addr !== 4'd15) begin
      miscompares++;
      $display("FAIL b2b_first: got done %b ovf %b addr %0d want 1/1/15", d_done, o_overflow, d_wr_addr);
    end
    step(1'b1, 1'b0, 6'($urandom));
    vectors++;
    if (d_busy !== 1'b1 || d_done !== 1'b0 || d_acc !== 10'd0 || d_wr_addr !== 4'd0 ||
        o_acc !== 8'd0 || o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_clear: got busy %b done %b acc %0d addr %0d oacc %0d oovf %b want 1/0/0/0/0/0",
               d_busy, d_done, d_acc, d_wr_addr, o_acc, o_overflow);
    end
    obs_d.delete();
    issued.delete();
    for (int i = 0; i < 3; i++) begin
      logic [5:0] p;
      p = 6'($urandom);
      step(1'b0, 1'b1, p);
      issued.push_back(p);
    end
    idle(12);
    vectors++;
    if (obs_d.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d writes want 3", obs_d.size());
    end else begin
      vectors++;
      if (obs_d[0].addr !== 4'd0 || obs_d[2].data !== 10'(exp_sum(3, 10))) begin
        miscompares++;
        $display("FAIL b2b_second: got addr %0d last %0d want 0/%0d", obs_d[0].addr, obs_d[2].data, exp_sum(3, 10));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prod_at[i] = 6'($urandom);
    test_reset();
    test_single_issue(1'b1);
    test_full_run();
    test_overflow();
    test_surplus();
    test_random_runs();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
